// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, R combinational read ports and a busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int N = 8,
  parameter int M = 32,
  parameter int A = $clog2(M),
  parameter int R = 2
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           w_enable0,
  input  logic [A-1:0]   Wd0,
  input  logic [N-1:0]   Wdata0,
  input  logic           w_enable1,
  input  logic [A-1:0]   Wd1,
  input  logic [N-1:0]   Wdata1,
  input  logic           set_busy,
  input  logic [A-1:0]   busy_addr,
  input  logic [R*A-1:0] Rs,
  output logic [R*N-1:0] Rs_data,
  output logic [R-1:0]   Rs_busy
);

  logic [N-1:0] regs_q [M];
  logic [N-1:0] regs_d [M];
  logic [M-1:0] busy_q;
  logic [M-1:0] busy_d;

  // Port 1 is applied after port 0 so it wins a same-address collision;
  // the busy set is applied last so a newly issued producer outranks a retiring one.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w_enable0) regs_d[Wd0] = Wdata0;
    if (w_enable1) regs_d[Wd1] = Wdata1;
    if (w_enable0) busy_d[Wd0] = 1'b0;
    if (w_enable1) busy_d[Wd1] = 1'b0;
    if (set_busy)  busy_d[busy_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < M; k++) regs_q[k] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [A-1:0] ra;
    ra      = '0;
    Rs_data = '0;
    Rs_busy = '0;
    for (int i = 0; i < R; i++) begin
      ra                 = Rs[i*A +: A];
      Rs_data[i*N +: N]  = regs_q[ra];
      Rs_busy[i]         = busy_q[ra];
`ifdef REG_FILE_BYPASS_EN
      if (ra != '0) begin
        if (w_enable1 && (Wd1 == ra)) begin
          Rs_data[i*N +: N] = Wdata1;
          Rs_busy[i]        = 1'b0;
        end else if (w_enable0 && (Wd0 == ra)) begin
          Rs_data[i*N +: N] = Wdata0;
          Rs_busy[i]        = 1'b0;
        end
      end
`endif
      // Outputs are held at zero for the whole reset assertion, including any forwarded write.
      if (!nReset) begin
        Rs_data[i*N +: N] = '0;
        Rs_busy[i]        = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (R=4 build) with an array-based reference model.
module tb_reg_file_mp;
  localparam int TN = 8;
  localparam int TM = 32;
  localparam int TA = 5;
  localparam int TR = 4;

  logic            clk = 1'b0;
  logic            nReset;
  logic            w_enable0, w_enable1, set_busy;
  logic [TA-1:0]   Wd0, Wd1, busy_addr;
  logic [TN-1:0]   Wdata0, Wdata1;
  logic [TR*TA-1:0] Rs;
  logic [TR*TN-1:0] Rs_data;
  logic [TR-1:0]   Rs_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [TN-1:0] m_reg  [TM];
  bit            m_busy [TM];

  reg_file_mp #(.N(TN), .M(TM), .R(TR)) dut (
    .clk(clk), .nReset(nReset),
    .w_enable0(w_enable0), .Wd0(Wd0), .Wdata0(Wdata0),
    .w_enable1(w_enable1), .Wd1(Wd1), .Wdata1(Wdata1),
    .set_busy(set_busy), .busy_addr(busy_addr),
    .Rs(Rs), .Rs_data(Rs_data), .Rs_busy(Rs_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: storage as plain arrays, updated with the write/scoreboard rules.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < TM; k++) begin
        m_reg[k]  = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      if (w_enable0 && Wd0 != 0) m_reg[Wd0] = Wdata0;
      if (w_enable1 && Wd1 != 0) m_reg[Wd1] = Wdata1;
      if (w_enable0) m_busy[Wd0] = 1'b0;
      if (w_enable1) m_busy[Wd1] = 1'b0;
      if (set_busy && busy_addr != 0) m_busy[busy_addr] = 1'b1;
    end
  end

  function automatic logic [TN-1:0] exp_data(input int i);
    int a;
    a = int'(Rs[i*TA +: TA]);
    if (!nReset || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (w_enable1 && int'(Wd1) == a) return Wdata1;
    if (w_enable0 && int'(Wd0) == a) return Wdata0;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int i);
    int a;
    a = int'(Rs[i*TA +: TA]);
    if (!nReset || a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if ((w_enable1 && int'(Wd1) == a) || (w_enable0 && int'(Wd0) == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < TR; i++) begin
        check($sformatf("model_data%0d", i), 32'(Rs_data[i*TN +: TN]), 32'(exp_data(i)));
        check($sformatf("model_busy%0d", i), 32'(Rs_busy[i]), 32'(exp_busy(i)));
      end
    end
  end

  function automatic logic [TN-1:0] rd(input int i);
    return Rs_data[i*TN +: TN];
  endfunction

  task automatic set_rs(input int i, input int a);
    Rs[i*TA +: TA] = TA'(a);
  endtask

  task automatic idle();
    w_enable0 = 1'b0; w_enable1 = 1'b0; set_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nReset = 1'b0;
    idle();
    Wd0 = '0; Wd1 = '0; busy_addr = '0; Wdata0 = '0; Wdata1 = '0; Rs = '0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data", 32'(Rs_data), 32'd0);
    check("reset_busy", 32'(Rs_busy), 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;

    // Reset clears storage asynchronously
    w_enable0 = 1'b1; Wd0 = 5; Wdata0 = 8'hA5; set_rs(0, 5);
    step(); idle();
    @(negedge clk);
    check("t1_write_r5", 32'(rd(0)), 32'hA5);
    #2 nReset = 1'b0;
    #1 check("t1_async_clear", 32'(rd(0)), 32'h0);
    @(posedge clk); #1;
    nReset = 1'b1;
    @(negedge clk);
    check("t1_after_release", 32'(rd(0)), 32'h0);

    // Register 0 ignores writes and busy set
    w_enable0 = 1'b1; Wd0 = 0; Wdata0 = 8'd133; set_busy = 1'b1; busy_addr = 0; set_rs(0, 0);
    @(negedge clk);
    check("t2_r0_same_cycle", 32'(rd(0)), 32'h0);
    step(); idle();
    @(negedge clk);
    check("t2_r0_data", 32'(rd(0)), 32'h0);
    check("t2_r0_busy", 32'(Rs_busy[0]), 32'h0);

    // Write collision and dual-port writes
    w_enable0 = 1'b1; Wd0 = 22; Wdata0 = 8'd11;
    w_enable1 = 1'b1; Wd1 = 22; Wdata1 = 8'd233;
    step(); idle(); set_rs(0, 22);
    @(negedge clk);
    check("t3_collision", 32'(rd(0)), 32'd233);
    w_enable0 = 1'b1; Wd0 = 31; Wdata0 = 8'd33;
    w_enable1 = 1'b1; Wd1 = 1;  Wdata1 = 8'd44;
    step(); idle(); set_rs(0, 31); set_rs(1, 1);
    @(negedge clk);
    check("t3_p0_r31", 32'(rd(0)), 32'd33);
    check("t3_p1_r1", 32'(rd(1)), 32'd44);
    @(posedge clk); #1;
    set_rs(0, 1); set_rs(1, 31);
    @(negedge clk);
    check("t3_swap_p0_r1", 32'(rd(0)), 32'd44);
    check("t3_swap_p1_r31", 32'(rd(1)), 32'd33);

    // Scoreboard set, clear by write, and set-wins
    set_busy = 1'b1; busy_addr = 7; set_rs(0, 7);
    step(); idle();
    @(negedge clk);
    check("t4_busy_set", 32'(Rs_busy[0]), 32'h1);
    w_enable0 = 1'b1; Wd0 = 7; Wdata0 = 8'd9;
    step(); idle();
    @(negedge clk);
    check("t4_cleared_busy", 32'(Rs_busy[0]), 32'h0);
    check("t4_cleared_data", 32'(rd(0)), 32'd9);
    set_busy = 1'b1; busy_addr = 7; w_enable1 = 1'b1; Wd1 = 7; Wdata1 = 8'd50;
    step(); idle();
    @(negedge clk);
    check("t4_set_wins_busy", 32'(Rs_busy[0]), 32'h1);
    check("t4_set_wins_data", 32'(rd(0)), 32'd50);

    // Forwarding behaviour on a busy register
    w_enable0 = 1'b1; Wd0 = 3; Wdata0 = 8'd12; set_busy = 1'b1; busy_addr = 3;
    step(); idle(); set_rs(0, 3);
    w_enable0 = 1'b1; Wd0 = 3; Wdata0 = 8'd77;
    @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
    check("t5_fwd_data", 32'(rd(0)), 32'd77);
    check("t5_fwd_busy", 32'(Rs_busy[0]), 32'h0);
`else
    check("t5_old_data", 32'(rd(0)), 32'd12);
    check("t5_old_busy", 32'(Rs_busy[0]), 32'h1);
`endif
    step(); idle();
    @(negedge clk);
    check("t5_new_data", 32'(rd(0)), 32'd77);
    check("t5_new_busy", 32'(Rs_busy[0]), 32'h0);

    // Four simultaneous reads, r7 still pending from earlier
    w_enable0 = 1'b1; Wd0 = 10; Wdata0 = 8'd101;
    w_enable1 = 1'b1; Wd1 = 11; Wdata1 = 8'd102;
    step();
    Wd0 = 12; Wdata0 = 8'd103; w_enable1 = 1'b0;
    step(); idle();
    set_rs(0, 10); set_rs(1, 11); set_rs(2, 12); set_rs(3, 7);
    @(negedge clk);
    check("t6_p0", 32'(rd(0)), 32'd101);
    check("t6_p1", 32'(rd(1)), 32'd102);
    check("t6_p2", 32'(rd(2)), 32'd103);
    check("t6_p3", 32'(rd(3)), 32'd50);
    check("t6_p3_busy", 32'(Rs_busy[3]), 32'h1);
    check("t6_p0_busy", 32'(Rs_busy[0]), 32'h0);

    // Mixed traffic checked against the model every cycle
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      w_enable0 = 1'($urandom_range(0, 1));
      w_enable1 = 1'($urandom_range(0, 1));
      set_busy  = 1'($urandom_range(0, 1));
      Wd0       = TA'($urandom_range(0, 7));
      Wd1       = TA'($urandom_range(0, 7));
      busy_addr = TA'($urandom_range(0, 7));
      Wdata0    = TN'($urandom);
      Wdata1    = TN'($urandom);
      for (int i = 0; i < TR; i++) set_rs(i, int'($urandom_range(0, 7)));
    end
    step(); idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
